// File: rtl/agen_fault_stage.sv
// AGEN -> MEM pipeline register; limit-check faults become a held,
// acknowledged #GP request that stalls upstream until accepted.
module agen_fault_stage #(
  parameter logic [7:0] FAULT_VECTOR = 8'h0D,
  parameter int         COUNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_address,
  input  logic [2:0]             in_segment,
  input  logic [2:0]             in_size,
  input  logic                   in_limit_fault,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_address,
  output logic [2:0]             out_segment,
  output logic [2:0]             out_size,
  output logic                   exc_req,
  output logic [7:0]             exc_vector,
  output logic [31:0]            exc_address,
  output logic [2:0]             exc_segment,
  input  logic                   exc_ack,
  output logic [COUNT_WIDTH-1:0] fault_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  state_e                 state_q;
  logic                   out_valid_q;
  logic [31:0]            out_address_q;
  logic [2:0]             out_segment_q;
  logic [2:0]             out_size_q;
  logic [7:0]             exc_vector_q;
  logic [31:0]            exc_address_q;
  logic [2:0]             exc_segment_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_d;
  logic                   accept;

  assign in_ready = ~reset & (state_q == RUN)
                  & (~out_valid_q | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;
  assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      out_valid_q   <= 1'b0;
      out_address_q <= '0;
      out_segment_q <= '0;
      out_size_q    <= '0;
      exc_vector_q  <= '0;
      exc_address_q <= '0;
      exc_segment_q <= '0;
      cnt_q         <= '0;
    end else if (flush) begin
      // flush also wins over a same-cycle exc_ack
      state_q      <= RUN;
      out_valid_q  <= 1'b0;
      exc_vector_q <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (accept && in_limit_fault) begin
            // any older op is leaving this cycle, so the slot empties
            state_q       <= FAULT;
            out_valid_q   <= 1'b0;
            exc_vector_q  <= FAULT_VECTOR;
            exc_address_q <= in_address;
            exc_segment_q <= in_segment;
            cnt_q         <= cnt_d;
          end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_address_q <= in_address;
            out_segment_q <= in_segment;
            out_size_q    <= in_size;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        FAULT: begin
          if (out_ready) out_valid_q <= 1'b0;
          if (exc_ack) begin
            state_q      <= RUN;
            exc_vector_q <= '0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign exc_req     = (state_q == FAULT);
  assign out_valid   = out_valid_q;
  assign out_address = out_address_q;
  assign out_segment = out_segment_q;
  assign out_size    = out_size_q;
  assign exc_vector  = exc_vector_q;
  assign exc_address = exc_address_q;
  assign exc_segment = exc_segment_q;
  assign fault_count = cnt_q;

endmodule
